// File: rtl/prediction_controller_pkg.sv
// ============================================================================
// Module      : prediction_controller_pkg
// Description : Shared mode encodings, chooser thresholds and reset values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prediction_controller_pkg;

    typedef enum logic [1:0] {
        MODE_WARMUP   = 2'd0,
        MODE_NORMAL   = 2'd1,
        MODE_FALLBACK = 2'd2
    } mode_e;

    localparam logic [1:0] c_choose_dp_thresh = 2'd2;
    localparam logic [2:0] c_dp_miss_limit    = 3'd4;
    localparam logic [1:0] c_table_reset_val  = 2'd1;

    function automatic int res_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : 2-bit saturating up/down counter with hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2 #(
    parameter logic [1:0] RESET_VAL = 2'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [1:0] o_cnt
);

    logic [1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RESET_VAL;
        end else if (i_inc && (r_cnt != 2'd3)) begin
            r_cnt <= r_cnt + 2'd1;
        end else if (i_dec && (r_cnt != 2'd0)) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/prediction_controller.sv
// ============================================================================
// Module      : prediction_controller
// Description : Tournament chooser between static and dynamic predictors with
//               warm-up and fallback modes, tracking branches IF -> ID -> EX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prediction_controller
    import prediction_controller_pkg::*;
#(
    parameter int IDX_W      = 4,
    parameter int WARMUP_N   = 8,
    parameter int FALLBACK_N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PL_stall_ex,
    input  logic             PL_flush,
    input  logic             branch_if,
    input  logic [IDX_W-1:0] pc_idx,
    input  logic             SP_prediction_result,
    input  logic             DP_prediction_result,
    input  logic             branch_ex,
    input  logic             actual_taken_ex,
    output logic             final_prediction,
    output logic             prediction_result_id,
    output logic             prediction_result_ex,
    output logic             mispredict_ex,
    output logic [1:0]       mode
);

    localparam int                 c_entries    = 1 << IDX_W;
    localparam int                 c_res_w      = res_width(WARMUP_N, FALLBACK_N);
    localparam logic [c_res_w-1:0] c_warmup_n   = c_res_w'(WARMUP_N);
    localparam logic [c_res_w-1:0] c_fallback_n = c_res_w'(FALLBACK_N);

    mode_e              r_mode;
    mode_e              w_mode_dec;
    logic [c_res_w-1:0] r_res;
    logic [c_res_w-1:0] w_res_inc;
    logic [2:0]         r_miss;
    logic [2:0]         w_miss_next;

    logic               r_id_valid, r_id_pred, r_id_sp, r_id_dp, r_id_used_dp;
    logic [IDX_W-1:0]   r_id_idx;
    logic               r_ex_valid, r_ex_pred, r_ex_sp, r_ex_dp, r_ex_used_dp;
    logic [IDX_W-1:0]   r_ex_idx;

    logic [1:0]         w_tbl [c_entries];
    logic [c_entries-1:0] w_inc;
    logic [c_entries-1:0] w_dec;
    logic               w_use_dp;
    logic               w_update;
    logic               w_train;

    // The unused encoding behaves exactly like WARMUP.
    always_comb begin
        case (r_mode)
            MODE_NORMAL:   w_mode_dec = MODE_NORMAL;
            MODE_FALLBACK: w_mode_dec = MODE_FALLBACK;
            default:       w_mode_dec = MODE_WARMUP;
        endcase
    end

    // Lookup reads the registered counters, so a same-cycle update is not visible.
    assign w_use_dp         = (w_mode_dec == MODE_NORMAL) && (w_tbl[pc_idx] >= c_choose_dp_thresh);
    assign final_prediction = branch_if & (w_use_dp ? DP_prediction_result : SP_prediction_result);

    assign w_update      = branch_ex & r_ex_valid & ~PL_stall_ex;
    assign w_train       = w_update & (r_ex_sp != r_ex_dp);
    assign mispredict_ex = branch_ex & r_ex_valid & (r_ex_pred != actual_taken_ex);

    generate
        for (genvar gi = 0; gi < c_entries; gi++) begin : g_table
            assign w_inc[gi] = w_train && (r_ex_idx == IDX_W'(gi)) && (r_ex_dp == actual_taken_ex);
            assign w_dec[gi] = w_train && (r_ex_idx == IDX_W'(gi)) && (r_ex_sp == actual_taken_ex);

            sat_counter2 #(
                .RESET_VAL (c_table_reset_val)
            ) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .i_inc (w_inc[gi]),
                .i_dec (w_dec[gi]),
                .o_cnt (w_tbl[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_valid   <= 1'b0;
            r_id_pred    <= 1'b0;
            r_id_sp      <= 1'b0;
            r_id_dp      <= 1'b0;
            r_id_used_dp <= 1'b0;
            r_id_idx     <= '0;
            r_ex_valid   <= 1'b0;
            r_ex_pred    <= 1'b0;
            r_ex_sp      <= 1'b0;
            r_ex_dp      <= 1'b0;
            r_ex_used_dp <= 1'b0;
            r_ex_idx     <= '0;
        end else if (!PL_stall_ex) begin
            r_id_valid   <= branch_if & ~PL_flush;
            r_id_pred    <= final_prediction;
            r_id_sp      <= SP_prediction_result;
            r_id_dp      <= DP_prediction_result;
            r_id_used_dp <= branch_if & w_use_dp;
            r_id_idx     <= pc_idx;
            r_ex_valid   <= r_id_valid;
            r_ex_pred    <= r_id_pred;
            r_ex_sp      <= r_id_sp;
            r_ex_dp      <= r_id_dp;
            r_ex_used_dp <= r_id_used_dp;
            r_ex_idx     <= r_id_idx;
        end
    end

    assign w_res_inc = r_res + c_res_w'(1);

    // Only misses on branches that were actually steered to DP build the streak.
    always_comb begin
        w_miss_next = r_miss;
        if (r_ex_dp == actual_taken_ex) begin
            w_miss_next = 3'd0;
        end else if (r_ex_used_dp && (r_miss != 3'd7)) begin
            w_miss_next = r_miss + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_WARMUP;
            r_res  <= '0;
            r_miss <= 3'd0;
        end else if (w_update) begin
            r_res  <= w_res_inc;
            r_miss <= w_miss_next;
            case (w_mode_dec)
                MODE_NORMAL: begin
                    if (w_miss_next >= c_dp_miss_limit) begin
                        r_mode <= MODE_FALLBACK;
                        r_miss <= 3'd0;
                        r_res  <= '0;
                    end
                end
                MODE_FALLBACK: begin
                    if (w_res_inc >= c_fallback_n) begin
                        r_mode <= MODE_NORMAL;
                        r_res  <= '0;
                    end
                end
                default: begin
                    if (w_res_inc >= c_warmup_n) begin
                        r_mode <= MODE_NORMAL;
                        r_res  <= '0;
                    end
                end
            endcase
        end
    end

    assign prediction_result_id = r_id_pred;
    assign prediction_result_ex = r_ex_pred;
    assign mode                 = r_mode;

endmodule

`default_nettype wire

// File: tb/tb_prediction_controller.sv
// ============================================================================
// Module      : tb_prediction_controller
// Description : Directed and random stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prediction_controller;

    localparam int IDX_W      = 4;
    localparam int WARMUP_N   = 8;
    localparam int FALLBACK_N = 16;
    localparam int NENT       = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             PL_stall_ex, PL_flush, branch_if;
    logic [IDX_W-1:0] pc_idx;
    logic             SP_prediction_result, DP_prediction_result;
    logic             branch_ex, actual_taken_ex;
    logic             final_prediction, prediction_result_id, prediction_result_ex;
    logic             mispredict_ex;
    logic [1:0]       mode;

    int checks = 0;
    int errors = 0;

    prediction_controller #(
        .IDX_W      (IDX_W),
        .WARMUP_N   (WARMUP_N),
        .FALLBACK_N (FALLBACK_N)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .PL_stall_ex          (PL_stall_ex),
        .PL_flush             (PL_flush),
        .branch_if            (branch_if),
        .pc_idx               (pc_idx),
        .SP_prediction_result (SP_prediction_result),
        .DP_prediction_result (DP_prediction_result),
        .branch_ex            (branch_ex),
        .actual_taken_ex      (actual_taken_ex),
        .final_prediction     (final_prediction),
        .prediction_result_id (prediction_result_id),
        .prediction_result_ex (prediction_result_ex),
        .mispredict_ex        (mispredict_ex),
        .mode                 (mode)
    );

    always #5 clk = ~clk;

    // Behavioural model: table of integers, two pipeline slots, mode counters.
    typedef struct {
        bit v;
        bit pred;
        bit sp;
        bit dp;
        bit used;
        int idx;
    } ent_t;

    int   m_tbl [NENT];
    int   m_mode, m_res, m_miss;
    ent_t m_id, m_ex;

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) m_tbl[i] = 1;
        m_mode = 0; m_res = 0; m_miss = 0;
        m_id = '{0, 0, 0, 0, 0, 0};
        m_ex = '{0, 0, 0, 0, 0, 0};
    endtask

    function automatic bit m_uses_dp();
        return (m_mode == 1) && (m_tbl[int'(pc_idx)] >= 2);
    endfunction

    function automatic bit m_final();
        if (!branch_if) return 1'b0;
        return m_uses_dp() ? DP_prediction_result : SP_prediction_result;
    endfunction

    task automatic m_resolve(input ent_t e, input bit act);
        if (e.sp != e.dp) begin
            if (e.dp == act) m_tbl[e.idx] = (m_tbl[e.idx] < 3) ? m_tbl[e.idx] + 1 : 3;
            else             m_tbl[e.idx] = (m_tbl[e.idx] > 0) ? m_tbl[e.idx] - 1 : 0;
        end
        if (e.dp == act)  m_miss = 0;
        else if (e.used)  m_miss = (m_miss < 7) ? m_miss + 1 : 7;
        m_res = (m_res + 1) % 32;
        if (m_mode == 0 && m_res >= WARMUP_N) begin
            m_mode = 1; m_res = 0;
        end else if (m_mode == 1 && m_miss >= 4) begin
            m_mode = 2; m_res = 0; m_miss = 0;
        end else if (m_mode == 2 && m_res >= FALLBACK_N) begin
            m_mode = 1; m_res = 0;
        end
    endtask

    task automatic m_step();
        ent_t nid;
        if (!PL_stall_ex) begin
            nid.v    = branch_if && !PL_flush;
            nid.pred = m_final();
            nid.sp   = SP_prediction_result;
            nid.dp   = DP_prediction_result;
            nid.used = branch_if && m_uses_dp();
            nid.idx  = int'(pc_idx);
            if (branch_ex && m_ex.v) m_resolve(m_ex, actual_taken_ex);
            m_ex = m_id;
            m_id = nid;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit bif, input int idx, input bit sp, input bit dp,
                          input bit bex, input bit act, input bit stall, input bit flush);
        branch_if            = bif;
        pc_idx               = IDX_W'(idx);
        SP_prediction_result = sp;
        DP_prediction_result = dp;
        branch_ex            = bex;
        actual_taken_ex      = act;
        PL_stall_ex          = stall;
        PL_flush             = flush;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic do_cycle();
        bit exp_misp;
        #1;
        exp_misp = branch_ex && m_ex.v && (m_ex.pred != actual_taken_ex);
        chk("final_prediction", {3'b0, final_prediction}, {3'b0, m_final()});
        chk("mispredict_ex", {3'b0, mispredict_ex}, {3'b0, exp_misp});
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("mode", {2'b0, mode}, 4'(m_mode));
        chk("prediction_result_id", {3'b0, prediction_result_id}, {3'b0, m_id.pred});
        chk("prediction_result_ex", {3'b0, prediction_result_ex}, {3'b0, m_ex.pred});
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 1, 1, 0, 0);
            do_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #12;
        chk("reset_mode", {2'b0, mode}, 4'd0);
        chk("reset_pred_id", {3'b0, prediction_result_id}, 4'd0);
        chk("reset_pred_ex", {3'b0, prediction_result_ex}, 4'd0);
        chk("reset_final", {3'b0, final_prediction}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Warm-up: eight resolved branches move WARMUP to NORMAL.
        for (int i = 0; i < 8; i++) begin
            set_in(1, 5, 1, 0, 1, 1, 0, 0);
            do_cycle();
        end
        drain(2);
        chk("warmup_to_normal", {2'b0, mode}, 4'd1);

        // Training idx 3 toward DP.
        for (int i = 0; i < 2; i++) begin
            set_in(1, 3, 0, 1, 1, 1, 0, 0);
            do_cycle();
        end
        drain(2);
        set_in(1, 3, 0, 1, 0, 0, 0, 0);
        #1;
        chk("trained_lookup_dp", {3'b0, final_prediction}, 4'd1);
        do_cycle();
        drain(2);

        // Four consecutive DP misses enter FALLBACK, sixteen updates leave it.
        for (int i = 0; i < 4; i++) begin
            set_in(1, 3, 0, 0, 1, 1, 0, 0);
            do_cycle();
        end
        drain(2);
        chk("normal_to_fallback", {2'b0, mode}, 4'd2);
        for (int i = 0; i < 16; i++) begin
            set_in(1, 0, 1, 1, 1, 1, 0, 0);
            do_cycle();
        end
        drain(2);
        chk("fallback_to_normal", {2'b0, mode}, 4'd1);

        // Stall holds both tracking slots.
        set_in(1, 2, 1, 0, 0, 0, 0, 0);
        do_cycle();
        set_in(1, 4, 0, 1, 0, 0, 0, 0);
        do_cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 9, 1, 0, 1, 0, 1, 0);
            do_cycle();
        end
        chk("stall_hold_id", {3'b0, prediction_result_id}, 4'd0);
        chk("stall_hold_ex", {3'b0, prediction_result_ex}, 4'd1);
        drain(2);

        // Flushed branch reaches EX invalid.
        set_in(1, 0, 1, 0, 0, 0, 0, 1);
        do_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle();
        set_in(0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        chk("flush_no_mispredict", {3'b0, mispredict_ex}, 4'd0);
        do_cycle();

        // Same-index lookup during update sees the old counter value.
        set_in(1, 7, 0, 1, 0, 0, 0, 0);
        do_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle();
        set_in(1, 7, 0, 1, 1, 1, 0, 0);
        #1;
        chk("same_idx_old_value", {3'b0, final_prediction}, 4'd0);
        do_cycle();
        drain(2);
        set_in(1, 7, 0, 1, 0, 0, 0, 0);
        #1;
        chk("same_idx_new_value", {3'b0, final_prediction}, 4'd1);
        do_cycle();
        drain(2);

        // Asynchronous reset with entries in flight.
        for (int i = 0; i < 2; i++) begin
            set_in(1, 1, 1, 1, 1, 1, 0, 0);
            do_cycle();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mode", {2'b0, mode}, 4'd0);
        chk("async_reset_pred_id", {3'b0, prediction_result_id}, 4'd0);
        chk("async_reset_pred_ex", {3'b0, prediction_result_ex}, 4'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 6, 1, 0, 1, 1, 0, 0);
        do_cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #3;
                rst_n = 1'b0;
                #1;
                chk("rand_reset_mode", {2'b0, mode}, 4'd0);
                m_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            set_in(($urandom_range(0, 9) < 7), int'($urandom_range(0, NENT - 1)),
                   1'($urandom), 1'($urandom),
                   ($urandom_range(0, 9) < 7), 1'($urandom),
                   ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10));
            do_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prediction_controller.md
PREDICTION_CONTROLLER -- requirements
Module: prediction_controller

Interface
REQ-001 Parameter IDX_W, default 4: chooser-table index width; the table holds 2^IDX_W entries.
REQ-002 Parameter WARMUP_N, default 8: number of resolved branches that must occur before the dynamic predictor is used.
REQ-003 Parameter FALLBACK_N, default 16: number of resolved branches spent in fallback mode.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 PL_stall_ex  in  1  pipeline stall; when high, all ID/EX tracking registers and the table hold.
REQ-007 PL_flush  in  1  mispredict flush; kills the in-flight ID entry.
REQ-008 branch_if  in  1  the instruction in IF is a conditional branch.
REQ-009 pc_idx  in  IDX_W  PC index bits of the IF branch.
REQ-010 SP_prediction_result  in  1  static-predictor direction for the IF branch.
REQ-011 DP_prediction_result  in  1  dynamic-predictor direction for the IF branch.
REQ-012 branch_ex  in  1  the EX instruction is a resolved branch this cycle.
REQ-013 actual_taken_ex  in  1  resolved direction in EX.
REQ-014 final_prediction  out  1  combinational selected direction for the IF branch.
REQ-015 prediction_result_id, prediction_result_ex  out  1 each  registered final prediction in ID / EX.
REQ-016 mispredict_ex  out  1  combinational: branch_ex & ex_valid & (prediction_result_ex != actual_taken_ex).
REQ-017 mode  out  2  current FSM state encoding.

Function
REQ-018 Chooser table: 2^IDX_W 2-bit saturating counters; a counter value >=2 selects DP, <2 selects SP.
REQ-019 FSM states: WARMUP=0, NORMAL=1, FALLBACK=2; encoding 3 is unused and SHALL decode to WARMUP.
REQ-020 Selection: WARMUP and FALLBACK -> final_prediction = SP_prediction_result; NORMAL -> the chooser table selects the source; when branch_if=0 the output is 0.
REQ-021 ID entry {valid, pred, sp, dp, idx} SHALL load from IF, and the EX entry from ID, each cycle PL_stall_ex=0; latency is one cycle IF->ID and one cycle ID->EX.
REQ-022 PL_flush=1 with PL_stall_ex=0 SHALL clear the ID valid bit; the EX entry still loads from ID, so a killed entry arrives in EX invalid.
REQ-023 An update occurs when branch_ex & ex_valid & !PL_stall_ex; with no update, no counter, table entry or FSM state changes.
REQ-024 Table update rule: only when sp != dp; increment, saturating at 3, if dp==actual; decrement, saturating at 0, if sp==actual.
REQ-025 A lookup and an update to the same index in the same cycle SHALL see the pre-update value.
REQ-026 A resolved counter (width ceil(log2(max(WARMUP_N,FALLBACK_N)))+1) SHALL count updates; a DP-miss counter (3 bits) SHALL count consecutive updates where the table selected DP and DP was wrong, cleared by any update where DP was right.
REQ-027 WARMUP -> NORMAL when the resolved count reaches WARMUP_N; the counter clears on every transition.
REQ-028 NORMAL -> FALLBACK when the DP-miss count reaches 4; the DP-miss counter clears.
REQ-029 FALLBACK -> NORMAL when the resolved count reaches FALLBACK_N; the table continues training in every state.

Reset
REQ-030 rst_n=0 SHALL immediately clear every ID/EX register, both counters and the outputs prediction_result_id and prediction_result_ex, set mode=WARMUP, and set every table entry to 1 (weakly SP).
REQ-031 Reset asserted mid-operation SHALL discard all in-flight entries; no update occurs on the first edge after release unless EX has been reloaded with a valid entry.

Structure
REQ-032 The mode encodings, the counter thresholds (2, 4) and the table-entry reset value 1 SHALL live in the shared define package.
REQ-033 One sub-module, sat_counter2 (a 2-bit saturating up/down counter with hold), SHALL be instantiated per table entry.

Verification
REQ-034 Reset: after rst_n release with 8 resolved branches, each with sp=1, dp=0, actual=1 -> mode goes 0->1 on the 8th update, and final_prediction equals sp throughout.
REQ-035 Training: in NORMAL, idx=3 with sp=0, dp=1, actual=1, repeated twice -> entry goes 1->2->3, and the next IF lookup at idx=3 returns dp.
REQ-036 Fallback: in NORMAL with entry >=2, 4 consecutive DP misses -> mode=2; after 16 further updates -> mode=1.
REQ-037 Stall/flush: PL_stall_ex=1 for 3 cycles holds prediction_result_id/ex and the table; PL_flush with branch_if=1 -> the entry reaches EX with valid=0 and mispredict_ex stays 0.
REQ-038 Simultaneous events: a same-index lookup and update in one cycle -> the lookup uses the old value; rst_n asserted mid-stream -> outputs are 0 asynchronously and mode=0.
